// File: rtl/uart_rx_ext_pkg.sv
// Shared definitions for the extended UART receiver: FSM states, parity modes, clog2.
`default_nettype none

package uart_rx_ext_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_bit_sampler.sv
// Two-flop rx synchroniser, falling-edge strobe and 3-sample majority voter.
`default_nettype none

module uart_bit_sampler #(
  parameter int OVERSAMPLE = 16,
  parameter int SW         = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx,
  input  logic          s_tick,
  input  logic [SW-1:0] s,
  output logic          fall,
  output logic          maj
);

  localparam logic [SW-1:0] S_A = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_B = SW'(OVERSAMPLE / 2);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;
  logic a_q,     a_d;
  logic b_q,     b_d;

  always_comb begin
    sync1_d = rx;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    a_d     = a_q;
    b_d     = b_q;
    if (s_tick && s == S_A) a_d = sync2_q;
    if (s_tick && s == S_B) b_d = sync2_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      a_q     <= 1'b1;
      b_q     <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  // The third vote is the live synchronised value, valid on the tick at s = M+1.
  assign fall = prev_q & ~sync2_q;
  assign maj  = (a_q & b_q) | (a_q & sync2_q) | (b_q & sync2_q);

endmodule

`default_nettype wire

// File: rtl/uart_rx_ext.sv
// Parametrised UART receiver with majority sampling, parity/framing/break flags
// and a valid/ready output register with sticky overrun.
`default_nettype none

module uart_rx_ext
  import uart_rx_ext_pkg::*;
#(
  parameter int N_BITS     = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_tick,
  input  logic              rx,
  input  logic              rx_ready,
  output logic              rx_valid,
  output logic [N_BITS-1:0] dout,
  output logic              parity_err,
  output logic              frame_err,
  output logic              break_det,
  output logic              overrun
);

  localparam int SW = clog2(OVERSAMPLE);
  localparam int NW = clog2(N_BITS + 1);
  localparam logic [SW-1:0] S_MID     = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(N_BITS - 1);
  localparam logic [NW-1:0] STOP_LAST = NW'(STOP_BITS - 1);

  state_e            state_q, state_d;
  logic [SW-1:0]     s_q, s_d;
  logic [NW-1:0]     n_q, n_d;
  logic [N_BITS-1:0] shreg_q, shreg_d;
  logic              perr_q, perr_d;
  logic              pbit_q, pbit_d;
  logic              ferr_q, ferr_d;
  logic              done_q, done_d;

  logic              rx_valid_q, rx_valid_d;
  logic [N_BITS-1:0] dout_q, dout_d;
  logic              parity_err_q, parity_err_d;
  logic              frame_err_q, frame_err_d;
  logic              break_q, break_d;
  logic              overrun_q, overrun_d;

  logic w_fall, w_maj, w_mid, w_end, w_accept;

  uart_bit_sampler #(
    .OVERSAMPLE(OVERSAMPLE),
    .SW        (SW)
  ) u_sampler (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .s_tick(s_tick),
    .s     (s_q),
    .fall  (w_fall),
    .maj   (w_maj)
  );

  assign w_mid    = s_tick && (s_q == S_MID);
  assign w_end    = s_tick && (s_q == S_LAST);
  assign w_accept = rx_valid_q & rx_ready;

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    n_d          = n_q;
    shreg_d      = shreg_q;
    perr_d       = perr_q;
    pbit_d       = pbit_q;
    ferr_d       = ferr_q;
    done_d       = 1'b0;
    rx_valid_d   = rx_valid_q;
    dout_d       = dout_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    break_d      = break_q;
    overrun_d    = overrun_q;

    if (state_q != ST_IDLE && s_tick) s_d = s_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (w_fall) begin
          state_d = ST_START;
          s_d     = '0;
          n_d     = '0;
          perr_d  = 1'b0;
          pbit_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      ST_START: begin
        if (w_mid && w_maj) begin
          state_d = ST_IDLE;
          s_d     = '0;
        end else if (w_end) begin
          state_d = ST_DATA;
          s_d     = '0;
          n_d     = '0;
        end
      end
      ST_DATA: begin
        if (w_mid) shreg_d = {w_maj, shreg_q[N_BITS-1:1]};
        if (w_end) begin
          s_d = '0;
          if (n_q == N_LAST) begin
            n_d     = '0;
            state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
          end else begin
            n_d = n_q + 1'b1;
          end
        end
      end
      ST_PAR: begin
        if (w_mid) begin
          pbit_d = w_maj;
          perr_d = (^shreg_q) != ((PARITY == PAR_ODD) ? ~w_maj : w_maj);
        end
        if (w_end) begin
          state_d = ST_STOP;
          s_d     = '0;
        end
      end
      ST_STOP: begin
        if (w_mid) begin
          if (!w_maj) ferr_d = 1'b1;
          // Completion at mid-bit of the last stop bit keeps the next start edge catchable.
          if (n_q == STOP_LAST) begin
            state_d = ST_IDLE;
            s_d     = '0;
            n_d     = '0;
            done_d  = 1'b1;
          end
        end else if (w_end) begin
          s_d = '0;
          n_d = n_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        s_d     = '0;
        n_d     = '0;
      end
    endcase

    if (w_accept) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end
    if (done_q) begin
      if (!rx_valid_q || rx_ready) begin
        rx_valid_d   = 1'b1;
        dout_d       = shreg_q;
        parity_err_d = perr_q;
        frame_err_d  = ferr_q;
        break_d      = (shreg_q == '0) && !pbit_q && ferr_q;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      s_q          <= '0;
      n_q          <= '0;
      shreg_q      <= '0;
      perr_q       <= 1'b0;
      pbit_q       <= 1'b0;
      ferr_q       <= 1'b0;
      done_q       <= 1'b0;
      rx_valid_q   <= 1'b0;
      dout_q       <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      break_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      n_q          <= n_d;
      shreg_q      <= shreg_d;
      perr_q       <= perr_d;
      pbit_q       <= pbit_d;
      ferr_q       <= ferr_d;
      done_q       <= done_d;
      rx_valid_q   <= rx_valid_d;
      dout_q       <= dout_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      break_q      <= break_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_valid   = rx_valid_q;
  assign dout       = dout_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign break_det  = break_q;
  assign overrun    = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_ext.sv
// Scoreboard bench for uart_rx_ext: an 8N1 instance and an 8E1 instance on separate rx lines.
`default_nettype none

module tb_uart_rx_ext;

  localparam int BIT_CLKS = 64;  // 16 ticks per bit, one tick every 4 clocks

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       bk;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       s_tick = 1'b0;
  logic [1:0] tick_cnt = 2'd0;
  logic       line = 1'b1;
  logic       sel = 1'b0;
  logic       rx0, rx1;
  logic       rdy0 = 1'b1;
  logic       rdy1 = 1'b1;

  logic       vld0, pe0, fe0, bk0, ov0;
  logic [7:0] dout0;
  logic       vld1, pe1, fe1, bk1, ov1;
  logic [7:0] dout1;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   failures = 0;
  bit   hs0 = 1'b0;
  bit   hs1 = 1'b0;

  always #10 clk = ~clk;

  always @(posedge clk) begin
    tick_cnt <= tick_cnt + 2'd1;
    s_tick   <= (tick_cnt == 2'd3);
  end

  assign rx0 = sel ? 1'b1 : line;
  assign rx1 = sel ? line : 1'b1;

  uart_rx_ext #(.N_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx0), .rx_ready(rdy0),
    .rx_valid(vld0), .dout(dout0), .parity_err(pe0), .frame_err(fe0),
    .break_det(bk0), .overrun(ov0)
  );

  uart_rx_ext #(.N_BITS(8), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(1)) u_dut1 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx1), .rx_ready(rdy1),
    .rx_valid(vld1), .dout(dout1), .parity_err(pe1), .frame_err(fe1),
    .break_det(bk1), .overrun(ov1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp_v);
    end
  endtask

  // Monitor: pop an expectation on every handshake and confirm rx_valid drops afterwards.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      hs0 = 1'b0;
      hs1 = 1'b0;
    end else begin
      if (hs0) chk("valid_pulse0", {31'd0, vld0}, 32'd0);
      if (hs1) chk("valid_pulse1", {31'd0, vld1}, 32'd0);
      hs0 = vld0 && rdy0;
      hs1 = vld1 && rdy1;
      if (hs0) begin
        if (q0.size() == 0) chk("unexpected_frame0", {31'd0, vld0}, 32'd0);
        else begin
          e = q0.pop_front();
          chk("dout0", {24'd0, dout0}, {24'd0, e.d});
          chk("flags0_pe_fe_bk", {29'd0, pe0, fe0, bk0}, {29'd0, e.pe, e.fe, e.bk});
        end
      end
      if (hs1) begin
        if (q1.size() == 0) chk("unexpected_frame1", {31'd0, vld1}, 32'd0);
        else begin
          e = q1.pop_front();
          chk("dout1", {24'd0, dout1}, {24'd0, e.d});
          chk("flags1_pe_fe_bk", {29'd0, pe1, fe1, bk1}, {29'd0, e.pe, e.fe, e.bk});
        end
      end
    end
  end

  task automatic drive_bit(input logic v);
    line = v;
    repeat (BIT_CLKS) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_en, input logic pbit,
                            input logic sbit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (par_en) drive_bit(pbit);
    drive_bit(sbit);
    drive_bit(1'b1);
  endtask

  task automatic push0(input logic [7:0] d, input logic pe, input logic fe, input logic bk);
    exp_t e;
    e = '{d: d, pe: pe, fe: fe, bk: bk};
    q0.push_back(e);
  endtask

  task automatic push1(input logic [7:0] d, input logic pe, input logic fe, input logic bk);
    exp_t e;
    e = '{d: d, pe: pe, fe: fe, bk: bk};
    q1.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while ((q0.size() != 0 || q1.size() != 0) && k < 3000) begin
      @(posedge clk);
      k++;
    end
    chk(name, q0.size() + q1.size(), 32'd0);
  endtask

  initial begin
    logic [7:0] c3;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs0", {19'd0, vld0, dout0, pe0, fe0, bk0, ov0}, 32'd0);
    chk("reset_outputs1", {19'd0, vld1, dout1, pe1, fe1, bk1, ov1}, 32'd0);
    reset = 1'b1;
    repeat (2 * BIT_CLKS) @(posedge clk);

    // 8N1 basic frame
    push0(8'hA5, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    wait_drain("drain_a5");

    // Even parity: correct bit, then corrupted bit
    sel = 1'b1;
    push1(8'h37, 1'b0, 1'b0, 1'b0);
    send_frame(8'h37, 1'b1, 1'b1, 1'b1);
    push1(8'h37, 1'b1, 1'b0, 1'b0);
    send_frame(8'h37, 1'b1, 1'b0, 1'b1);
    wait_drain("drain_parity");
    sel = 1'b0;

    // 4-tick glitch on an idle line must not produce a frame
    line = 1'b0;
    repeat (16) @(posedge clk);
    line = 1'b1;
    repeat (2 * BIT_CLKS) @(posedge clk);
    @(negedge clk);
    chk("false_start_no_valid", {31'd0, vld0}, 32'd0);

    // One-tick low pulse in the middle of bit 3 of 0xFF
    push0(8'hFF, 1'b0, 1'b0, 1'b0);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        line = 1'b1;
        repeat (30) @(posedge clk);
        line = 1'b0;
        repeat (4) @(posedge clk);
        line = 1'b1;
        repeat (30) @(posedge clk);
      end else begin
        drive_bit(1'b1);
      end
    end
    drive_bit(1'b1);
    drive_bit(1'b1);
    wait_drain("drain_glitch_ff");

    // Framing error, then a break
    push0(8'h55, 1'b0, 1'b1, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    wait_drain("drain_frame_err");
    push0(8'h00, 1'b0, 1'b1, 1'b1);
    line = 1'b0;
    repeat (12 * BIT_CLKS) @(posedge clk);
    line = 1'b1;
    repeat (2 * BIT_CLKS) @(posedge clk);
    wait_drain("drain_break");

    // Overrun: second frame dropped while the first is held
    rdy0 = 1'b0;
    push0(8'h11, 1'b0, 1'b0, 1'b0);
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("held_valid", {31'd0, vld0}, 32'd1);
    chk("held_dout", {24'd0, dout0}, 32'h11);
    chk("overrun_set", {31'd0, ov0}, 32'd1);
    @(posedge clk);
    #1 rdy0 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("valid_after_accept", {31'd0, vld0}, 32'd0);
    chk("overrun_cleared", {31'd0, ov0}, 32'd0);
    wait_drain("drain_overrun");

    // Reset mid-frame of 0xC3 discards it
    c3 = 8'hC3;
    drive_bit(1'b0);
    drive_bit(c3[0]);
    drive_bit(c3[1]);
    repeat (20) @(posedge clk);
    #1 reset = 1'b0;
    line = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("midframe_reset_valid", {31'd0, vld0}, 32'd0);
    reset = 1'b1;
    repeat (2 * BIT_CLKS) @(posedge clk);
    push0(8'h3C, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    wait_drain("drain_after_reset");
    repeat (BIT_CLKS) @(posedge clk);
    chk("queues_empty_end", q0.size() + q1.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
